// File: rtl/puf_req_sched.sv
// Round-robin scheduler sharing one PUF core between NUM_REQ requesters.
// Define PUF_REQ_SCHED_ZEROIZE_EN to scrub response and challenge after every handshake.
module puf_req_sched #(
    parameter int NUM_REQ     = 2,
    parameter int CHAL_W      = 128,
    parameter int RESP_W      = 256,
    parameter int WARMUP_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024,
    localparam int GNT_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ-1:0]         req_mode_i,
    input  logic [NUM_REQ*CHAL_W-1:0]  req_chal_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic [RESP_W-1:0]          rsp_data_o,
    output logic                       rsp_err_o,
    output logic                       puf_enable_o,
    output logic                       puf_mode_o,
    output logic                       puf_ready_cha_o,
    output logic [CHAL_W-1:0]          puf_chal_o,
    input  logic                       puf_rsp_valid_i,
    input  logic [RESP_W-1:0]          puf_rsp_i,
    output logic                       busy_o,
    output logic [GNT_W-1:0]           grant_o
);

    localparam int CNT_MAX = (WARMUP_CYC > TIMEOUT_CYC) ? WARMUP_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENABLE,
        ST_CHAL,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [GNT_W-1:0]    r_rr;
    logic [GNT_W-1:0]    r_grant;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [RESP_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic [CHAL_W-1:0]   r_chal;
    logic [CHAL_W-1:0]   r_puf_chal;
    logic                r_puf_enable;
    logic                r_puf_mode;
    logic                r_puf_cha;
    logic                r_busy;

    logic                w_any_req;
    logic                w_hi_found;
    logic [GNT_W-1:0]    w_hi_idx;
    logic [GNT_W-1:0]    w_lo_idx;
    logic [GNT_W-1:0]    w_gnt_idx;
    logic [CHAL_W-1:0]   w_sel_chal;
    logic                w_sel_mode;

    assign w_any_req = |req_valid_i;

    // Requesters at or above the pointer beat those below it; the downward scan
    // leaves the lowest qualifying index in each candidate.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid_i[j]) begin
                w_lo_idx = GNT_W'(j);
                if (GNT_W'(j) >= r_rr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = GNT_W'(j);
                end
            end
        end
        w_gnt_idx  = w_hi_found ? w_hi_idx : w_lo_idx;
        w_sel_chal = '0;
        w_sel_mode = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (GNT_W'(j) == w_gnt_idx) begin
                w_sel_chal = req_chal_i[j*CHAL_W +: CHAL_W];
                w_sel_mode = req_mode_i[j];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_next_state = ST_ENABLE;
            ST_ENABLE: if (r_cnt == '0) w_next_state = ST_CHAL;
            ST_CHAL:   w_next_state = ST_WAIT;
            ST_WAIT:   if (puf_rsp_valid_i || (r_cnt == '0)) w_next_state = ST_RESP;
            ST_RESP:   if (rsp_ready_i[r_grant]) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: the wide response register is reset too, so a dropped response never resurfaces.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt        <= '0;
            r_rr         <= '0;
            r_grant      <= '0;
            r_req_ready  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_chal       <= '0;
            r_puf_chal   <= '0;
            r_puf_enable <= 1'b0;
            r_puf_mode   <= 1'b0;
            r_puf_cha    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_puf_cha   <= 1'b0;
            r_busy      <= (w_next_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_req_ready  <= NUM_REQ'(1) << w_gnt_idx;
                        r_grant      <= w_gnt_idx;
                        r_rr         <= (w_gnt_idx == GNT_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + GNT_W'(1);
                        r_chal       <= w_sel_chal;
                        r_puf_mode   <= w_sel_mode;
                        r_puf_enable <= 1'b1;
                        r_cnt        <= CNT_W'(WARMUP_CYC - 1);
                    end
                end
                ST_ENABLE: begin
                    if (r_cnt == '0) begin
                        r_puf_cha  <= 1'b1;
                        r_puf_chal <= r_chal;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_CHAL: r_cnt <= CNT_W'(TIMEOUT_CYC - 1);
                ST_WAIT: begin
                    // A response arriving on the last counted cycle still wins over the timeout.
                    if (puf_rsp_valid_i) begin
                        r_rsp_data   <= puf_rsp_i;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= NUM_REQ'(1) << r_grant;
                        r_puf_enable <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_rsp_data   <= '0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= NUM_REQ'(1) << r_grant;
                        r_puf_enable <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i[r_grant]) begin
                        r_rsp_valid <= '0;
`ifdef PUF_REQ_SCHED_ZEROIZE_EN
                        r_rsp_data  <= '0;
                        r_chal      <= '0;
`endif
                    end
                end
                default: ;
            endcase
`ifdef PUF_REQ_SCHED_ZEROIZE_EN
            if ((w_next_state != ST_CHAL) && (w_next_state != ST_WAIT)) r_puf_chal <= '0;
`endif
        end
    end

    assign req_ready_o     = r_req_ready;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_data_o      = r_rsp_data;
    assign rsp_err_o       = r_rsp_err;
    assign puf_enable_o    = r_puf_enable;
    assign puf_mode_o      = r_puf_mode;
    assign puf_ready_cha_o = r_puf_cha;
    assign puf_chal_o      = r_puf_chal;
    assign busy_o          = r_busy;
    assign grant_o         = r_grant;

endmodule

// File: doc/puf_req_sched.md
Name: puf_req_sched

Overview:
Round-robin scheduler that shares the single PUF core between NUM_REQ requesters (e.g. key-derivation, attestation). It accepts a challenge from one requester at a time and sequences the core: enable, warm-up, challenge strobe, wait for a valid response. It returns the captured response, or a timeout error, to the granted requester. It sits between the requester fabric and the PUF core instance, alongside the register-mapped PUF wrapper.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
CHAL_W, 128, challenge width in bits
RESP_W, 256, response width in bits
WARMUP_CYC, 4, cycles enable is held before the challenge strobe (>=1)
TIMEOUT_CYC, 1024, maximum cycles spent in WAIT before an error is returned (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  NUM_REQ  per-requester challenge request
req_ready_o  out  NUM_REQ  one-hot accept strobe
req_mode_i  in  NUM_REQ  per-requester PUF mode bit
req_chal_i  in  NUM_REQ*CHAL_W  challenges; requester k occupies bits [k*CHAL_W +: CHAL_W]
rsp_valid_o  out  NUM_REQ  one-hot response valid
rsp_ready_i  in  NUM_REQ  per-requester response accept
rsp_data_o  out  RESP_W  response data (shared bus)
rsp_err_o  out  1  response is a timeout error, qualified by rsp_valid_o
puf_enable_o  out  1  PUF core enable
puf_mode_o  out  1  PUF core mode
puf_ready_cha_o  out  1  one-cycle challenge strobe
puf_chal_o  out  CHAL_W  challenge to the core
puf_rsp_valid_i  in  1  core response valid
puf_rsp_i  in  RESP_W  core response
busy_o  out  1  FSM not in IDLE
grant_o  out  $clog2(NUM_REQ) (min 1)  index of the current or last grant

Behaviour:
- Reset (rst_i sampled high at a clk_i edge), effective in every state, mid-operation included:
  - state=IDLE; all outputs 0; rr pointer=0; internal registers cleared.
  - A pending response is dropped.
- All outputs are registered.
- IDLE:
  - If any req_valid_i is set, grant the first requester at or after the rr pointer (wrapping).
  - Same cycle: req_ready_o[g]=1 for one cycle; latch chal, mode and g.
  - Next state ENABLE; rr pointer = g+1 mod NUM_REQ.
- ENABLE:
  - puf_enable_o=1, puf_mode_o=latched mode; counter loads WARMUP_CYC-1.
  - Hold until the counter reaches 0, then go to CHAL. ENABLE lasts exactly WARMUP_CYC cycles.
- CHAL (1 cycle):
  - puf_ready_cha_o=1, puf_chal_o=latched chal.
  - Timeout counter loads TIMEOUT_CYC-1. Next state WAIT.
- WAIT:
  - puf_chal_o stays stable; puf_enable_o stays 1 from ENABLE through WAIT.
  - If puf_rsp_valid_i=1: capture puf_rsp_i, err=0, go to RESP.
  - Else if the counter is 0: data=0, err=1, go to RESP.
  - Simultaneous valid and counter=0: the valid response wins.
  - puf_rsp_valid_i outside WAIT is ignored.
- RESP:
  - puf_enable_o=0.
  - rsp_valid_o[g]=1, rsp_data_o=captured data, rsp_err_o=err; all held stable until rsp_ready_i[g]=1.
  - On that edge go to IDLE; rsp_valid_o clears next cycle.
  - rsp_ready_i of non-granted requesters is ignored.
- No back-to-back bypass: IDLE always spends at least 1 cycle, so a new request is granted no sooner than the cycle after the RESP handshake.
- A requester dropping req_valid_i before its grant simply loses its slot; no error.
- Best-case grant-to-rsp_valid latency: WARMUP_CYC + 2 cycles + core latency.

Optional Feature:
PUF_REQ_SCHED_ZEROIZE_EN
- Defined:
  - After the RESP handshake, the response register, rsp_data_o and the latched challenge are cleared to 0 on the same edge that enters IDLE.
  - puf_chal_o is driven 0 whenever state is not CHAL or WAIT.
- Undefined: the last response and challenge stay on rsp_data_o and puf_chal_o until overwritten.

Test Plan:
- Reset then idle: no requests for 20 cycles -> all outputs 0, busy_o=0.
- Single request, WARMUP_CYC=4: req 0, chal=128'hA5..A5, mode=1; core returns 256'h1234 three cycles after the strobe:
  - puf_enable_o high 4 cycles before the 1-cycle puf_ready_cha_o with chal A5..A5.
  - rsp_valid_o[0] with data 256'h1234, err=0.
  - rsp_valid_o held while rsp_ready_i[0]=0 for 5 cycles.
- Round-robin, both requesters valid continuously: grants alternate 0,1,0,1 -> grant_o sequence 0,1,0,1 and req_ready_o one-hot each time.
- Timeout, TIMEOUT_CYC=16, core silent: rsp_valid_o with err=1 and data=0 exactly 16 cycles after CHAL; puf_enable_o drops in RESP.
- Tie at timeout: puf_rsp_valid_i arrives on the cycle the counter hits 0 -> err=0 and data captured.
- Reset in WAIT and reset in RESP: rst_i high for 1 cycle -> IDLE and all outputs 0 next cycle; the next grant goes to requester 0. With ZEROIZE_EN: rsp_data_o=0 the cycle after a handshake.
